// File: rtl/ram1k_ctl_pkg.sv
// Shared types and widths for the 1Kx16 static-RAM bank controller.
// Optional build macro: RAM1K_CTL_PARITY_EN (adds a parity bit stored per word).
package ram1k_ctl_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    WPULSE = 3'd2,
    HOLD   = 3'd3,
    READ   = 3'd4
  } state_e;

  // Bit that makes the stored word plus parity contain an odd number of ones.
  function automatic logic odd_par(input logic [DATA_W-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The last-grant register only moves when
// the grant is actually consumed (update_i), so a request dropped before
// acceptance leaves the priority unchanged.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  // 1 = port 1 was granted last; resets to 1 so that port 0 wins first.
  logic last_q;

  // Grant the lone requester, or on contention the one not served last.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

  // Remember which port was served when a grant is consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else if (update_i) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/ram1k_ctl.sv
// Two-port request front end for a bank of sixteen 1Kx1 static RAMs.
// Writes run SETUP -> WPULSE (WE_PULSE clocks) -> HOLD; reads hold CE for
// READ_WAIT clocks and sample ram_do on the last READ edge.
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high; ready is only offered in IDLE, to one port.
// Optional build macro: RAM1K_CTL_PARITY_EN (ram_pdi/ram_pdo/rsp_perr).
module ram1k_ctl
  import ram1k_ctl_pkg::*;
#(
  parameter int WE_PULSE  = 1,  // 1..4
  parameter int READ_WAIT = 1   // 1..4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic              req0_we,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_ce_n,
  output logic              ram_we_n,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do,
`ifdef RAM1K_CTL_PARITY_EN
  output logic              ram_pdi,
  input  logic              ram_pdo,
  output logic              rsp_perr,
`endif
  output logic [2:0]        dbg_state
);

  localparam logic [1:0] WE_LAST = 2'(WE_PULSE - 1);
  localparam logic [1:0] RD_LAST = 2'(READ_WAIT - 1);

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic              port_q;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] di_q;
  logic              ce_n_q;
  logic              we_n_q;
  logic              rsp0_q;
  logic              rsp1_q;
  logic [DATA_W-1:0] rdata_q;
`ifdef RAM1K_CTL_PARITY_EN
  logic              pdi_q;
  logic              perr_q;
`endif

  logic [1:0]        gnt;
  logic              idle;
  logic              accept;
  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_arb (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .req_i    ({req1_valid, req0_valid}),
    .update_i (accept),
    .gnt_o    (gnt)
  );

  // Ready is withheld while reset is asserted even though the state reads IDLE.
  assign idle       = (state_q == IDLE);
  assign req0_ready = reset_n & idle & gnt[0];
  assign req1_ready = reset_n & idle & gnt[1];
  assign accept     = (req0_ready & req0_valid) | (req1_ready & req1_valid);

  assign sel_port  = gnt[1];
  assign sel_we    = sel_port ? req1_we    : req0_we;
  assign sel_addr  = sel_port ? req1_addr  : req0_addr;
  assign sel_wdata = sel_port ? req1_wdata : req0_wdata;

  // Sequencer: every RAM pin and response is a flop so the strobes are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      port_q  <= 1'b0;
      a_q     <= '0;
      di_q    <= '0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      rdata_q <= '0;
`ifdef RAM1K_CTL_PARITY_EN
      pdi_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            port_q <= sel_port;
            a_q    <= sel_addr;
            ce_n_q <= 1'b0;
            we_n_q <= 1'b1;
            cnt_q  <= '0;
            if (sel_we) begin
              di_q    <= sel_wdata;
`ifdef RAM1K_CTL_PARITY_EN
              pdi_q   <= odd_par(sel_wdata);
`endif
              state_q <= SETUP;
            end else begin
              state_q <= READ;
            end
          end
        end
        SETUP: begin
          we_n_q  <= 1'b0;
          state_q <= WPULSE;
        end
        WPULSE: begin
          if (cnt_q == WE_LAST) begin
            we_n_q  <= 1'b1;
            state_q <= HOLD;
            rsp0_q  <= ~port_q;
            rsp1_q  <= port_q;
            rdata_q <= '0;
`ifdef RAM1K_CTL_PARITY_EN
            perr_q  <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        HOLD: begin
          ce_n_q  <= 1'b1;
          state_q <= IDLE;
        end
        READ: begin
          if (cnt_q == RD_LAST) begin
            ce_n_q  <= 1'b1;
            state_q <= IDLE;
            rsp0_q  <= ~port_q;
            rsp1_q  <= port_q;
            rdata_q <= ram_do;
`ifdef RAM1K_CTL_PARITY_EN
            perr_q  <= ~(^{ram_do, ram_pdo});
`endif
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: begin
          ce_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp_rdata  = rdata_q;
  assign ram_a      = a_q;
  assign ram_di     = di_q;
  assign ram_ce_n   = ce_n_q;
  assign ram_we_n   = we_n_q;
  assign dbg_state  = state_q;
`ifdef RAM1K_CTL_PARITY_EN
  assign ram_pdi    = pdi_q;
  assign rsp_perr   = perr_q;
`endif

endmodule

// File: tb/tb_ram1k_ctl.sv
// Bench for ram1k_ctl: two instances (A: WE_PULSE=1 READ_WAIT=2,
// B: WE_PULSE=4 READ_WAIT=1) share the request inputs, each with its own RAM model.
module tb_ram1k_ctl;
  import ram1k_ctl_pkg::*;

  localparam int A_WE = 1;
  localparam int A_RW = 2;
  localparam int B_WE = 4;
  localparam int B_RW = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared request inputs ----------------
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_we = 1'b0, req1_we = 1'b0;
  logic [9:0]  req0_addr = '0, req1_addr = '0;
  logic [15:0] req0_wdata = '0, req1_wdata = '0;

  // ---------------- per-instance outputs ----------------
  logic        a_rdy0, a_rdy1, a_rsp0, a_rsp1, a_ce_n, a_we_n;
  logic [15:0] a_rdata, a_di, a_do;
  logic [9:0]  a_a;
  logic [2:0]  a_state;
  logic        b_rdy0, b_rdy1, b_rsp0, b_rsp1, b_ce_n, b_we_n;
  logic [15:0] b_rdata, b_di, b_do;
  logic [9:0]  b_a;
  logic [2:0]  b_state;
`ifdef RAM1K_CTL_PARITY_EN
  logic a_pdi, a_perr, b_pdi, b_perr;
  logic a_pdo = 1'b0;
  logic b_pdo = 1'b0;
  logic last_pdi, last_perr;
`endif

  ram1k_ctl #(.WE_PULSE(A_WE), .READ_WAIT(A_RW)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(a_rdy0), .req1_ready(a_rdy1),
    .req0_we(req0_we), .req1_we(req1_we),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .rsp0_valid(a_rsp0), .rsp1_valid(a_rsp1), .rsp_rdata(a_rdata),
    .ram_a(a_a), .ram_ce_n(a_ce_n), .ram_we_n(a_we_n), .ram_di(a_di), .ram_do(a_do),
`ifdef RAM1K_CTL_PARITY_EN
    .ram_pdi(a_pdi), .ram_pdo(a_pdo), .rsp_perr(a_perr),
`endif
    .dbg_state(a_state)
  );

  ram1k_ctl #(.WE_PULSE(B_WE), .READ_WAIT(B_RW)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(b_rdy0), .req1_ready(b_rdy1),
    .req0_we(req0_we), .req1_we(req1_we),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .rsp0_valid(b_rsp0), .rsp1_valid(b_rsp1), .rsp_rdata(b_rdata),
    .ram_a(b_a), .ram_ce_n(b_ce_n), .ram_we_n(b_we_n), .ram_di(b_di), .ram_do(b_do),
`ifdef RAM1K_CTL_PARITY_EN
    .ram_pdi(b_pdi), .ram_pdo(b_pdo), .rsp_perr(b_perr),
`endif
    .dbg_state(b_state)
  );

  // ---------------- RAM bank models ----------------
  logic [15:0] a_mem [1024];
  logic [15:0] b_mem [1024];
  always @(posedge clk) if (!a_ce_n && !a_we_n) a_mem[a_a] <= a_di;
  always @(posedge clk) if (!b_ce_n && !b_we_n) b_mem[b_a] <= b_di;
  assign a_do = a_ce_n ? 16'hDEAD : a_mem[a_a];
  assign b_do = b_ce_n ? 16'hDEAD : b_mem[b_a];

  // ---------------- observed-instance mux ----------------
  logic        obs_b = 1'b0;
  logic        o_rdy0, o_rdy1, o_rsp0, o_rsp1, o_ce_n, o_we_n;
  logic [15:0] o_rdata, o_di;
  logic [9:0]  o_a;
  logic [2:0]  o_state;
  assign o_rdy0  = obs_b ? b_rdy0  : a_rdy0;
  assign o_rdy1  = obs_b ? b_rdy1  : a_rdy1;
  assign o_rsp0  = obs_b ? b_rsp0  : a_rsp0;
  assign o_rsp1  = obs_b ? b_rsp1  : a_rsp1;
  assign o_ce_n  = obs_b ? b_ce_n  : a_ce_n;
  assign o_we_n  = obs_b ? b_we_n  : a_we_n;
  assign o_rdata = obs_b ? b_rdata : a_rdata;
  assign o_di    = obs_b ? b_di    : a_di;
  assign o_a     = obs_b ? b_a     : a_a;
  assign o_state = obs_b ? b_state : a_state;

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver: one transaction on one port ----------------
  task automatic run_txn(input logic dut_b, input logic port, input logic we,
                         input logic [9:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_rdata, input string tag);
    int wp, rw, ce_cnt, we_cnt, rsp_k, wait_n, end_k;
    logic [15:0] rdata_cap;
    logic other, unstable;
    logic [2:0] st1, st_end;
    wp = dut_b ? B_WE : A_WE;
    rw = dut_b ? B_RW : A_RW;
    end_k = we ? wp + 3 : rw + 1;
    ce_cnt = 0; we_cnt = 0; rsp_k = 0; rdata_cap = '0;
    other = 1'b0; unstable = 1'b0; st1 = '0; st_end = '1;
    obs_b = dut_b;
    @(negedge clk);
    req0_we = we; req1_we = we;
    req0_addr = addr; req1_addr = addr;
    req0_wdata = wdata; req1_wdata = wdata;
    req0_valid = ~port; req1_valid = port;
    #1;
    wait_n = 0;
    while (!(port ? o_rdy1 : o_rdy0) && wait_n < 20) begin
      @(negedge clk); #1; wait_n++;
    end
    if (wait_n >= 20) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    check({tag, "_ready"}, {30'd0, o_rdy1, o_rdy0}, port ? 32'd2 : 32'd1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      if (k == 1) st1 = o_state;
      if (k == end_k) st_end = o_state;
`ifdef RAM1K_CTL_PARITY_EN
      if (k == 1) last_pdi = dut_b ? b_pdi : a_pdi;
`endif
      if (!o_ce_n) begin
        ce_cnt++;
        if (o_a !== addr || (we && o_di !== wdata)) unstable = 1'b1;
      end
      if (!o_we_n) we_cnt++;
      if (port ? o_rsp1 : o_rsp0) begin
        if (rsp_k == 0) begin
          rsp_k = k;
          rdata_cap = o_rdata;
`ifdef RAM1K_CTL_PARITY_EN
          last_perr = dut_b ? b_perr : a_perr;
`endif
        end else other = 1'b1;
      end
      if (port ? o_rsp0 : o_rsp1) other = 1'b1;
    end
    check({tag, "_first_state"}, {29'd0, st1}, we ? 32'(SETUP) : 32'(READ));
    check({tag, "_ce_cycles"}, ce_cnt, we ? wp + 2 : rw);
    check({tag, "_we_cycles"}, we_cnt, we ? wp : 0);
    check({tag, "_rsp_cycle"}, rsp_k, we ? wp + 2 : rw + 1);
    check({tag, "_rdata"}, {16'd0, rdata_cap}, we ? 32'd0 : {16'd0, exp_rdata});
    check({tag, "_idle_after"}, {29'd0, st_end}, 32'(IDLE));
    check({tag, "_stray_rsp"}, {31'd0, other}, 32'd0);
    check({tag, "_addr_data_stable"}, {31'd0, unstable}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        dut_b;
    logic        port;
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // dut_b, port, we, addr, wdata, exp_rdata
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 10'h155, 16'hA5C3, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 10'h155, 16'h0000, 16'hA5C3};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 10'h000, 16'hFFFF, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 16'hFFFF};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 10'h3FF, 16'h0001, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 10'h3FF, 16'h0000, 16'h0001};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 10'h155, 16'h0000, 16'hA5C3};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 10'h155, 16'h5A3C, 16'h0000};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 10'h155, 16'h0000, 16'h5A3C};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 10'h3FF, 16'hBEEF, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 10'h3FF, 16'h0000, 16'hBEEF};

    // ---- reset values, with a request pending during reset ----
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk); #1;
    check("rst_ce_n", {31'd0, a_ce_n}, 32'd1);
    check("rst_we_n", {31'd0, a_we_n}, 32'd1);
    check("rst_ram_a", {22'd0, a_a}, 32'd0);
    check("rst_ram_di", {16'd0, a_di}, 32'd0);
    check("rst_rsp", {30'd0, a_rsp1, a_rsp0}, 32'd0);
    check("rst_rdata", {16'd0, a_rdata}, 32'd0);
    check("rst_state", {29'd0, a_state}, 32'(IDLE));
    check("rst_ready", {30'd0, a_rdy1, a_rdy0}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // ---- table-driven transactions ----
    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].dut_b, vecs[i].port, vecs[i].we, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end
    obs_b = 1'b0;

    // ---- asynchronous reset in the middle of a write pulse ----
    begin
      int n;
      logic seen;
      @(negedge clk);
      req0_we = 1'b1; req0_addr = 10'h100; req0_wdata = 16'h7777; req0_valid = 1'b1;
      #1;
      n = 0;
      while (a_state != WPULSE && n < 10) begin
        @(negedge clk);
        req0_valid = 1'b0;
        #1; n++;
      end
      check("rstmid_reached_wpulse", {29'd0, a_state}, 32'(WPULSE));
      check("rstmid_we_low_before", {31'd0, a_we_n}, 32'd0);
      reset_n = 1'b0;
      #1;
      check("rstmid_we_n_async", {31'd0, a_we_n}, 32'd1);
      check("rstmid_ce_n_async", {31'd0, a_ce_n}, 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk); #1;
        if (a_rsp0 || a_rsp1) seen = 1'b1;
      end
      check("rstmid_no_rsp", {31'd0, seen}, 32'd0);
    end

`ifdef RAM1K_CTL_PARITY_EN
    // ---- parity bit written and checked ----
    run_txn(1'b0, 1'b0, 1'b1, 10'h2AA, 16'h0001, 16'h0000, "par_wr");
    check("par_pdi", {31'd0, last_pdi}, 32'd0);
    check("par_wr_perr", {31'd0, last_perr}, 32'd0);
    a_pdo = 1'b1;
    run_txn(1'b0, 1'b0, 1'b0, 10'h2AA, 16'h0000, 16'h0001, "par_rd_bad");
    check("par_perr_set", {31'd0, last_perr}, 32'd1);
    a_pdo = 1'b0;
    run_txn(1'b0, 1'b1, 1'b0, 10'h2AA, 16'h0000, 16'h0001, "par_rd_ok");
    check("par_perr_clr", {31'd0, last_perr}, 32'd0);
`endif

    // ---- round-robin with both ports continuously valid ----
    run_txn(1'b0, 1'b0, 1'b1, 10'h010, 16'h1111, 16'h0000, "rr_pre0");
    run_txn(1'b0, 1'b1, 1'b1, 10'h020, 16'h2222, 16'h0000, "rr_pre1");
    obs_b = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    req0_we = 1'b0; req1_we = 1'b0;
    req0_addr = 10'h010; req1_addr = 10'h020;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rr_ready_in_reset", {30'd0, a_rdy1, a_rdy0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    begin
      int grants, cyc;
      logic [15:0] got;
      grants = 0; cyc = 0;
      while (cyc < 40 && !(grants == 4 && exp_q0.size() == 0 && exp_q1.size() == 0)) begin
        if (a_rsp0 && a_rsp1) check("rr_both_rsp", 32'd1, 32'd0);
        if (a_rsp0) begin
          if (exp_q0.size() == 0) check("rr_unexpected_rsp0", 32'd1, 32'd0);
          else begin got = exp_q0.pop_front(); check("rr_rsp0_data", {16'd0, a_rdata}, {16'd0, got}); end
        end
        if (a_rsp1) begin
          if (exp_q1.size() == 0) check("rr_unexpected_rsp1", 32'd1, 32'd0);
          else begin got = exp_q1.pop_front(); check("rr_rsp1_data", {16'd0, a_rdata}, {16'd0, got}); end
        end
        if ((a_rdy0 || a_rdy1) && grants < 4) begin
          check($sformatf("rr_grant%0d", grants), {30'd0, a_rdy1, a_rdy0},
                (grants % 2 == 0) ? 32'd1 : 32'd2);
          if (a_rdy0) exp_q0.push_back(16'h1111);
          else        exp_q1.push_back(16'h2222);
          grants++;
        end
        @(negedge clk);
        if (grants >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        #1;
        cyc++;
      end
      check("rr_grant_count", grants, 4);
      check("rr_drained", exp_q0.size() + exp_q1.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
